reg_writeback_queue: RTL

Collects register write-back requests from two producers and drains them into the register file write port (enable_write/write_id/write_data), one per cycle. The two producers are the single-cycle ALU path and the multi-cycle memory/divide path. Requests are buffered in a small in-order FIFO so the register file write port can be held off without losing results. The block also exposes a forwarding lookup over pending entries, so the read side sees values not yet committed to the register file.

---
 rtl/reg_writeback_queue_pkg.sv | 21 ++
 rtl/reg_writeback_queue_fwd_match.sv | 32 +++
 rtl/reg_writeback_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and constants for the register write-back queue.
package reg_writeback_queue_pkg;

    localparam int ID_W     = 5;
    localparam int DATA_W   = 32;
    localparam int WB_DEPTH = 4;

    typedef logic [ID_W-1:0]   reg_id_t;
    typedef logic [DATA_W-1:0] op_t;

    typedef struct packed {
        reg_id_t id;
        op_t     data;
    } wb_entry_t;

    // Register 0 is hard-wired, so writes to it are dropped.
    function automatic logic id_writable(input reg_id_t id);
        return (id != ID_W'(0));
    endfunction

endpackage

// File: rtl/reg_writeback_queue_fwd_match.sv
// Forwarding lookup: finds the youngest valid entry targeting a queried register.
module wb_fwd_match
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t        entries_i [DEPTH],
    input  logic [DEPTH-1:0] valid_i,
    input  logic [PTR_W-1:0] head_i,
    input  reg_id_t          query_i,
    output logic             hit_o,
    output op_t              data_o
);

    // Walk from oldest (head) to youngest so later matches override earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             match;
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        match  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx    = head_i + PTR_W'(k);
            match  = valid_i[idx] && (entries_i[idx].id == query_i) && id_writable(query_i);
            hit_o  = hit_o | match;
            data_o = match ? entries_i[idx].data : data_o;
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order write-back FIFO merging ALU and memory results into the register file
// write port, with forwarding lookups over entries not yet committed.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  reg_id_t          alu_id,
    input  op_t              alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  reg_id_t          mem_id,
    input  op_t              mem_data,
    output logic             mem_ready,
    input  logic             wb_hold,
    output logic             enable_write,
    output reg_id_t          write_id,
    output op_t              write_data,
    input  reg_id_t          lookup1_id,
    input  reg_id_t          lookup2_id,
    output logic             lookup1_hit,
    output logic             lookup2_hit,
    output op_t              lookup1_data,
    output op_t              lookup2_data,
    output logic [CNT_W-1:0] pending_count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    logic             alu_acc_s;
    logic             mem_acc_s;
    logic             enq_s;
    logic             pop_s;
    wb_entry_t        enq_entry_s;
    logic             hit1_s, hit2_s;
    op_t              data1_s, data2_s;

    // Handshake: single enqueue slot per cycle with ALU priority; id 0 is acked but dropped.
    always_comb begin
        alu_ready   = ~full_q & ~rst;
        mem_ready   = ~full_q & ~rst & ~alu_valid;
        alu_acc_s   = alu_valid & alu_ready;
        mem_acc_s   = mem_valid & mem_ready;
        enq_entry_s = '0;
        enq_s       = 1'b0;
        if (alu_acc_s) begin
            enq_entry_s = '{id: alu_id, data: alu_data};
            enq_s       = id_writable(alu_id);
        end else if (mem_acc_s) begin
            enq_entry_s = '{id: mem_id, data: mem_data};
            enq_s       = id_writable(mem_id);
        end else begin
            enq_s       = 1'b0;
        end
        pop_s = ~rst & ~empty_q & ~wb_hold;
    end

    // Next-state for pointers, valid mask and occupancy.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end else begin
            head_d          = head_q;
        end
        if (enq_s) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end else begin
            tail_d          = tail_q;
        end
        count_d = count_q + CNT_W'(enq_s) - CNT_W'(pop_s);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage; contents only matter where the valid mask is set.
    always_ff @(posedge clk) begin
        if (enq_s && !rst) begin
            entries_q[tail_q] <= enq_entry_s;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .query_i   (lookup1_id),
        .hit_o     (hit1_s),
        .data_o    (data1_s)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .query_i   (lookup2_id),
        .hit_o     (hit2_s),
        .data_o    (data2_s)
    );

    // Output drive; reset forces the idle view even before the reset edge lands.
    always_comb begin
        enable_write  = pop_s;
        if (!rst && !empty_q) begin
            write_id   = entries_q[head_q].id;
            write_data = entries_q[head_q].data;
        end else begin
            write_id   = '0;
            write_data = '0;
        end
        lookup1_hit   = hit1_s & ~rst;
        lookup2_hit   = hit2_s & ~rst;
        lookup1_data  = rst ? '0 : data1_s;
        lookup2_data  = rst ? '0 : data2_s;
        pending_count = count_q;
        full          = full_q & ~rst;
        empty         = empty_q | rst;
    end

endmodule
